// File: rtl/mips_multicycle_ctrl_pkg.sv
// Purpose: shared types and encodings for the multi-cycle MIPS-subset control FSM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, opcode/funct constants, ALU/PC/operand-B select codes, trap causes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_R     = 4'd3,
        EXEC_I   = 4'd4,
        WB_I     = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        WB_MEM   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_CMP  = 4'b1001;

    localparam logic [1:0] PC_SRC_ALU = 2'd0;
    localparam logic [1:0] PC_SRC_TGT = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Purpose: bundle between the control FSM and the datapath/memory port.
// Latency: n/a (wires only).
// Backpressure: mem_req is held by the controller until the memory answers with mem_ready.
// master = controller (drives strobes/selects), slave = datapath side (drives decoder fields, flags, mem_ready).
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             alu_zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_op;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             instr_done;
    logic [CNT_W-1:0] retired;
    logic             trap;
    logic [1:0]       trap_cause;

    modport master (
        input  opcode, funct, alu_zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
               instr_done, retired, trap, trap_cause
    );

    modport slave (
        output opcode, funct, alu_zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
               instr_done, retired, trap, trap_cause
    );
endinterface

// File: rtl/mips_multicycle_ctrl_mem_wait_timer.sv
// Purpose: counts stalled memory cycles and flags a bus timeout at WAIT_LIMIT.
// Latency: timeout is combinational from the count and the current req/ready.
// Backpressure: none; a ready in the limit cycle suppresses the timeout.
// Ports: clk/rst, clr (restart on entry to a memory state), req/ready (current handshake), timeout.
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic req,
    input  logic ready,
    output logic timeout
);
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr || ready) begin
            cnt <= 8'd0;
        end else if (req) begin
            cnt <= cnt + 8'd1;
        end
    end

    // The current stalled cycle is the WAIT_LIMIT-th one when the count already holds LIMIT-1.
    assign timeout = req && !ready && (cnt == 8'(WAIT_LIMIT - 1));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Purpose: multi-cycle control FSM stepping the shared ALU/memory/regfile datapath.
// Latency: 3 (beq, j), 4 (R-type, addi, sw), 5 (lw) cycles with zero-wait memory.
// Backpressure: stalls in FETCH/MEM_RD/MEM_WR until mem_ready; traps after WAIT_LIMIT stalled cycles.
// Ports: clk, rst (sync, active-high), bus (master modport: decoder fields, flags, strobes, count, trap).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_multicycle_ctrl_if.master bus
);
    state_t           state, state_nxt;
    logic [1:0]       cause_q, cause_nxt;
    logic [3:0]       rop_q, rop_nxt;      // ALU op chosen for the R-type in flight
    logic             store_q, store_nxt;  // MEM_ADDR continues to MEM_WR when set
    logic [CNT_W-1:0] retired_q;
    logic             timeout;
    logic             wait_enter;
    logic             ready_eff;

    // mem_ready only counts while a request is outstanding.
    assign ready_eff  = bus.mem_ready && bus.mem_req;
    assign wait_enter = (state_nxt != state) &&
                        (state_nxt == FETCH || state_nxt == MEM_RD || state_nxt == MEM_WR);

    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (wait_enter),
        .req     (bus.mem_req),
        .ready   (ready_eff),
        .timeout (timeout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            cause_q   <= CAUSE_NONE;
            rop_q     <= ALU_ADD;
            store_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
            rop_q   <= rop_nxt;
            store_q <= store_nxt;
            if (bus.instr_done) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        rop_nxt   = rop_q;
        store_nxt = store_q;
        case (state)
            FETCH: begin
                if (ready_eff) begin
                    state_nxt = DECODE;
                end else if (timeout) begin
                    state_nxt = TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE: begin
                        state_nxt = EXEC_R;
                        case (bus.funct)
                            FN_ADD, FN_ADDU: rop_nxt = ALU_ADD;
                            FN_SUB:          rop_nxt = ALU_SUB;
                            FN_AND:          rop_nxt = ALU_AND;
                            default: begin
                                state_nxt = TRAP;
                                cause_nxt = CAUSE_ILLEGAL;
                            end
                        endcase
                    end
                    OP_ADDI: state_nxt = EXEC_I;
                    OP_LW: begin
                        state_nxt = MEM_ADDR;
                        store_nxt = 1'b0;
                    end
                    OP_SW: begin
                        state_nxt = MEM_ADDR;
                        store_nxt = 1'b1;
                    end
                    OP_BEQ: state_nxt = BRANCH;
                    OP_J:   state_nxt = JUMP;
                    default: begin
                        state_nxt = TRAP;
                        cause_nxt = CAUSE_ILLEGAL;
                    end
                endcase
            end
            EXEC_R:   state_nxt = WB_R;
            EXEC_I:   state_nxt = WB_I;
            MEM_ADDR: state_nxt = store_q ? MEM_WR : MEM_RD;
            MEM_RD, MEM_WR: begin
                if (ready_eff) begin
                    state_nxt = (state == MEM_RD) ? WB_MEM : FETCH;
                end else if (timeout) begin
                    state_nxt = TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            WB_R, WB_I, WB_MEM, BRANCH, JUMP: state_nxt = FETCH;
            TRAP:     state_nxt = TRAP;
            default:  state_nxt = FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_src        = PC_SRC_ALU;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.alu_op        = ALU_ADD;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.instr_done    = 1'b0;
        bus.trap          = 1'b0;
        case (state)
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            DECODE: begin
                // Branch target is precomputed here while the opcode is dispatched.
                bus.alu_src_b = SRCB_IMM_SH;
            end
            EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = rop_q;
            end
            WB_R: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
            end
            EXEC_I, MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            WB_I: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
            end
            MEM_WR: begin
                bus.mem_req    = 1'b1;
                bus.mem_we     = 1'b1;
                bus.iord       = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_CMP;
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = PC_SRC_TGT;
                bus.instr_done    = 1'b1;
            end
            JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_src     = PC_SRC_JMP;
                bus.instr_done = 1'b1;
            end
            TRAP: begin
                bus.trap = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.retired    = retired_q;
    assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction-level model produces per-cycle expected outputs,
// a compare process drives each cycle and checks, and literal checks pin latency/count/trap values.
module tb_mips_multicycle_ctrl;
    localparam int WL = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       reg_write, reg_dst, mem_to_reg, instr_done, trap;
        logic [1:0] trap_cause;
    } outs_t;

    typedef struct {
        logic          rst;
        logic [5:0]    op;
        logic [5:0]    fn;
        logic          mr;
        logic          az;
        logic          chk;
        outs_t         exp;
        logic [CW-1:0] ret;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    stim_t sq[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_done = 0;
    bit busy = 0;
    int m_ret = 0;
    logic [5:0] cur_op, cur_fn;
    logic cur_az;

    mips_multicycle_ctrl_if #(.CNT_W(CW)) bus ();

    mips_multicycle_ctrl #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, want);
        end
    endtask

    // ---------------- instruction-level model ----------------
    task automatic push(input logic r, input logic mr, input outs_t e, input logic c);
        stim_t s;
        s.rst = r; s.op = cur_op; s.fn = cur_fn; s.mr = mr; s.az = cur_az;
        s.chk = c; s.exp = e; s.ret = CW'(m_ret);
        sq.push_back(s);
        if (c && e.instr_done) m_ret = (m_ret + 1) % (1 << CW);
        if (r) m_ret = 0;
    endtask

    task automatic reset_cycle();
        push(1'b1, 1'b0, '0, 1'b0);
    endtask

    function automatic outs_t o_fetch(input logic rdy);
        outs_t o = '0;
        o.mem_req = 1; o.alu_src_b = 2'd1; o.ir_write = rdy; o.pc_write = rdy;
        return o;
    endfunction

    function automatic outs_t o_mem(input logic wr, input logic rdy);
        outs_t o = '0;
        o.mem_req = 1; o.iord = 1; o.mem_we = wr; o.instr_done = wr & rdy;
        return o;
    endfunction

    task automatic trap_tail(input logic [1:0] c);
        outs_t o = '0;
        o.trap = 1; o.trap_cause = c;
        for (int i = 0; i < 3; i++) push(1'b0, 1'b1, o, 1'b1);
    endtask

    // fw: stalled FETCH cycles, mw: stalled memory cycles, rmid: reset instead of the mem ready
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic az,
                            input int fw, input int mw, input bit rmid);
        outs_t e;
        bit is_r, legal_r;
        cur_op = op; cur_fn = fn; cur_az = az;
        for (int i = 0; i < fw && i < WL; i++) push(1'b0, 1'b0, o_fetch(1'b0), 1'b1);
        if (fw >= WL) begin trap_tail(2'd2); return; end
        push(1'b0, 1'b1, o_fetch(1'b1), 1'b1);
        e = '0; e.alu_src_b = 2'd3;
        push(1'b0, 1'b1, e, 1'b1);
        is_r = (op == 6'h00);
        legal_r = is_r && (fn == 6'h20 || fn == 6'h21 || fn == 6'h22 || fn == 6'h24);
        if (is_r && !legal_r) begin trap_tail(2'd1); return; end
        if (is_r) begin
            e = '0; e.alu_src_a = 1;
            e.alu_op = (fn == 6'h22) ? 4'b0001 : (fn == 6'h24) ? 4'b0010 : 4'b0000;
            push(1'b0, 1'b1, e, 1'b1);
            e = '0; e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1;
            push(1'b0, 1'b1, e, 1'b1);
        end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
            e = '0; e.alu_src_a = 1; e.alu_src_b = 2'd2;
            push(1'b0, 1'b1, e, 1'b1);
            if (op == 6'h08) begin
                e = '0; e.reg_write = 1; e.instr_done = 1;
                push(1'b0, 1'b1, e, 1'b1);
                return;
            end
            for (int i = 0; i < mw && i < WL; i++) push(1'b0, 1'b0, o_mem(op == 6'h2B, 1'b0), 1'b1);
            if (rmid) begin reset_cycle(); return; end
            if (mw >= WL) begin trap_tail(2'd2); return; end
            push(1'b0, 1'b1, o_mem(op == 6'h2B, 1'b1), 1'b1);
            if (op == 6'h23) begin
                e = '0; e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1;
                push(1'b0, 1'b1, e, 1'b1);
            end
        end else if (op == 6'h04) begin
            e = '0; e.alu_src_a = 1; e.alu_op = 4'b1001; e.pc_write_cond = 1;
            e.pc_src = 2'd1; e.instr_done = 1;
            push(1'b0, 1'b1, e, 1'b1);
        end else if (op == 6'h02) begin
            e = '0; e.pc_write = 1; e.pc_src = 2'd2; e.instr_done = 1;
            push(1'b0, 1'b1, e, 1'b1);
        end else begin
            trap_tail(2'd1);
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        stim_t s;
        outs_t got;
        bus.opcode = '0; bus.funct = '0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (sq.size() > 0) begin
                busy = 1;
                s = sq.pop_front();
                rst = s.rst; bus.opcode = s.op; bus.funct = s.fn;
                bus.mem_ready = s.mr; bus.alu_zero = s.az;
                #1;
                cyc++;
                got = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                       bus.pc_write_cond, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                       bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.instr_done, bus.trap,
                       bus.trap_cause};
                if (s.chk) begin
                    total++;
                    if (got !== s.exp) begin
                        bad++;
                        $display("FAIL outs cyc=%0d: got %h, want %h", cyc, got, s.exp);
                    end
                    total++;
                    if (bus.retired !== s.ret) begin
                        bad++;
                        $display("FAIL retired cyc=%0d: got %0d, want %0d", cyc, bus.retired, s.ret);
                    end
                end
                if (bus.instr_done === 1'b1) last_done = cyc;
                busy = 0;
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((sq.size() > 0 || busy) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sq.size());
            sq.delete();
        end
        #1;
    endtask

    task automatic lat(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input logic az, input int fw, input int mw, input int want);
        int s0;
        drain();
        s0 = cyc;
        do_instr(op, fn, az, fw, mw, 1'b0);
        drain();
        check(nm, last_done - s0, want);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_cycle();
        drain();
        check("reset_retired", int'(bus.retired), 0);
        check("reset_trap", int'(bus.trap), 0);
        check("reset_cause", int'(bus.trap_cause), 0);
        check("reset_mem_req", int'(bus.mem_req), 1);

        lat("add_lat", 6'h00, 6'h20, 1'b0, 0, 0, 4);
        check("add_retired", int'(bus.retired), 1);
        lat("sub_lat", 6'h00, 6'h22, 1'b0, 0, 0, 4);
        lat("and_lat", 6'h00, 6'h24, 1'b0, 0, 0, 4);
        lat("addu_lat", 6'h00, 6'h21, 1'b0, 0, 0, 4);
        lat("addi_lat", 6'h08, 6'h00, 1'b0, 0, 0, 4);
        lat("sw_lat", 6'h2B, 6'h00, 1'b0, 0, 0, 4);
        lat("lw_wait_lat", 6'h23, 6'h00, 1'b0, 0, 3, 8);
        check("lw_no_trap", int'(bus.trap), 0);
        lat("beq_z1_lat", 6'h04, 6'h00, 1'b1, 0, 0, 3);
        lat("beq_z0_lat", 6'h04, 6'h00, 1'b0, 0, 0, 3);
        lat("j_lat", 6'h02, 6'h00, 1'b0, 0, 0, 3);
        check("retired_after_10", int'(bus.retired), 10);

        do_instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);
        drain();
        check("ill_op_trap", int'(bus.trap), 1);
        check("ill_op_cause", int'(bus.trap_cause), 1);
        check("ill_op_no_req", int'(bus.mem_req), 0);
        reset_cycle();
        drain();
        check("post_trap_retired", int'(bus.retired), 0);
        check("post_trap_fetch", int'(bus.mem_req), 1);

        do_instr(6'h00, 6'h2A, 1'b0, 0, 0, 1'b0);
        drain();
        check("ill_fn_cause", int'(bus.trap_cause), 1);
        reset_cycle();

        do_instr(6'h00, 6'h20, 1'b0, WL, 0, 1'b0);
        drain();
        check("fetch_to_trap", int'(bus.trap), 1);
        check("fetch_to_cause", int'(bus.trap_cause), 2);
        reset_cycle();

        lat("fetch_rdy_at_limit", 6'h00, 6'h20, 1'b0, WL - 1, 0, 7);
        check("fetch_rdy_no_trap", int'(bus.trap), 0);

        do_instr(6'h23, 6'h00, 1'b0, 0, WL, 1'b0);
        drain();
        check("memrd_to_cause", int'(bus.trap_cause), 2);
        reset_cycle();

        for (int i = 0; i < 15; i++) do_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0);
        drain();
        check("j15_retired", int'(bus.retired), 15);
        do_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0);
        drain();
        check("j16_wrap", int'(bus.retired), 0);

        do_instr(6'h2B, 6'h00, 1'b0, 0, 2, 1'b1);
        drain();
        check("rst_mid_wr_we", int'(bus.mem_we), 0);
        check("rst_mid_wr_iord", int'(bus.iord), 0);
        lat("j_after_rst", 6'h02, 6'h00, 1'b0, 0, 0, 3);
        check("final_retired", int'(bus.retired), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
